// File: rtl/adder_pkg.sv
// Shared types and constants for the nibble-serial adder and its four-bit slice.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } adder_state_t;

    localparam int NIBBLE_W = 4;

    function automatic int nibble_count(input int width);
        return width / NIBBLE_W;
    endfunction

endpackage

// File: rtl/four_bit_adder.sv
// Combinational four-bit ripple-carry slice; with NIBBLE_SERIAL_ADDER_OVERFLOW_EN
// it also exposes the carry into bit 3 for signed-overflow detection.
module four_bit_adder
    import adder_pkg::*;
(
    input  logic                carryIn,
    input  logic [NIBBLE_W-1:0] x,
    input  logic [NIBBLE_W-1:0] y,
    output logic [NIBBLE_W-1:0] s,
    output logic                carryOut
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
    ,
    output logic                c3
`endif
);

    logic [NIBBLE_W:0] c;

    // NOTE: every output of a combinational block is assigned on every path,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = carryIn;
        for (int i = 0; i < NIBBLE_W; i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
    end

    assign carryOut = c[NIBBLE_W];

`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
    assign c3 = c[NIBBLE_W-1];
`endif

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle adder: {carryOut, sum} = x + y + carryIn, one nibble per clock, LSB first.
// Optional signed-overflow output enabled by NIBBLE_SERIAL_ADDER_OVERFLOW_EN.
module nibble_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             carryIn,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] sum,
    output logic             carryOut
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int NIBBLES = nibble_count(WIDTH);
    localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
        $error("nibble_serial_adder: WIDTH must be a positive multiple of 4");
    end

    adder_state_t     state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d, sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d, cout_q, cout_d, out_valid_q, out_valid_d;

    logic [NIBBLE_W-1:0] slice_s;
    logic                slice_c;

`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
    logic ovf_q, ovf_d, slice_c3;
`endif

    four_bit_adder u_slice (
        .carryIn  (carry_q),
        .x        (x_q[cnt_q*NIBBLE_W +: NIBBLE_W]),
        .y        (y_q[cnt_q*NIBBLE_W +: NIBBLE_W]),
        .s        (slice_s),
        .carryOut (slice_c)
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
        ,
        .c3       (slice_c3)
`endif
    );

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        cout_d      = cout_q;
        out_valid_d = out_valid_q;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
        ovf_d       = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (inValid) begin
                    x_d     = x;
                    y_d     = y;
                    carry_d = carryIn;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // The carry only travels between nibbles through carry_q.
                sum_d[cnt_q*NIBBLE_W +: NIBBLE_W] = slice_s;
                carry_d = slice_c;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    cout_d      = slice_c;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
                    ovf_d       = slice_c3 ^ slice_c;
`endif
                end
            end
            DONE: begin
                if (outReady) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sum_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    // NOTE: the operand latches are pure datapath, only read in RUN after being
    // loaded, so they carry no reset.
    always_ff @(posedge clk) begin
        x_q <= x_d;
        y_q <= y_d;
    end

    assign inReady  = (state_q == IDLE);
    assign outValid = out_valid_q;
    assign sum      = sum_q;
    assign carryOut = cout_q;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
    assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder (WIDTH=16); overflow checks are active
// when NIBBLE_SERIAL_ADDER_OVERFLOW_EN is defined.
module tb_nibble_serial_adder;

    localparam int W   = 16;
    localparam int LAT = W / 4;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] x_i = '0;
    logic [W-1:0] y_i = '0;
    logic         cin_i = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum_o;
    logic         cout_o;
    logic         ovf_o;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    bit   seen = 1'b0;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .inValid  (in_valid),
        .inReady  (in_ready),
        .x        (x_i),
        .y        (y_i),
        .carryIn  (cin_i),
        .outValid (out_valid),
        .outReady (out_ready),
        .sum      (sum_o),
        .carryOut (cout_o)
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
        ,
        .overflow (ovf_o)
`endif
    );

`ifndef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
    assign ovf_o = 1'b0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the whole operands.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        exp_t         e;
        logic [W:0]   full;
        longint       sa, sb, r;
        full   = {1'b0, a} + {1'b0, b} + (W+1)'(c);
        e.sum  = full[W-1:0];
        e.cout = full[W];
        sa     = a[W-1] ? longint'(a) - (longint'(1) << W) : longint'(a);
        sb     = b[W-1] ? longint'(b) - (longint'(1) << W) : longint'(b);
        r      = sa + sb + longint'(c);
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
        e.ovf  = (r > ((longint'(1) << (W-1)) - 1)) || (r < -(longint'(1) << (W-1)));
`else
        e.ovf  = 1'b0;
        if (r == 0) e.ovf = 1'b0;
`endif
        e.acc  = 0;
        return e;
    endfunction

    // Monitor: compares every presented result cycle against the queue head.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                if (!seen) begin
                    check("latency", 64'(cyc - exp_q[0].acc), 64'(LAT));
                    seen = 1'b1;
                end
                check("sum", sum_o, exp_q[0].sum);
                check("carry_out", cout_o, exp_q[0].cout);
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
                check("overflow", ovf_o, exp_q[0].ovf);
`endif
                check("in_ready_in_done", in_ready, 0);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input bit rdy, input bit disturb);
        exp_t e;
        int   guard;
        @(posedge clk);
        #2;
        x_i = a; y_i = b; cin_i = c; in_valid = 1'b1; out_ready = rdy;
        guard = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            guard++;
            if (guard > 50) begin
                check("accept_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        e     = model(a, b, c);
        e.acc = cyc;
        exp_q.push_back(e);
        #1;
        in_valid = 1'b0;
        x_i = W'($urandom); y_i = W'($urandom); cin_i = 1'($urandom);
        if (disturb) begin
            x_i = 16'hAAAA;
            in_valid = 1'b1;
            repeat (2) @(posedge clk);
            #2 in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int guard = 0;
        forever begin
            @(negedge clk);
            if (in_ready && !out_valid && exp_q.size() == 0) break;
            guard++;
            if (guard > 60) begin
                check("idle_timeout", 0, 1);
                exp_q.delete();
                seen = 1'b0;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input int hold, input bit disturb);
        int guard = 0;
        send(a, b, c, hold == 0, disturb);
        if (hold > 0) begin
            while (!out_valid && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            check("done_reached", out_valid, 1);
            repeat (hold) begin
                @(negedge clk);
                check("in_ready_backpressure", in_ready, 0);
            end
            @(posedge clk);
            #2 out_ready = 1'b1;
            @(negedge clk);
            @(negedge clk);
            check("idle_after_accept_in_ready", in_ready, 1);
            check("idle_after_accept_out_valid", out_valid, 0);
        end
        wait_idle();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_sum", sum_o, 0);
        check("reset_carry_out", cout_o, 0);
        check("reset_overflow", ovf_o, 0);

        run_op(16'h1234, 16'h4321, 1'b0, 0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
        run_op(16'hFFFF, 16'h0000, 1'b1, 0, 1'b0);
        run_op(16'h00F0, 16'h0010, 1'b0, 5, 1'b0);
        run_op(16'h0001, 16'h0001, 1'b0, 0, 1'b1);
        run_op(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
        run_op(16'h8000, 16'h8000, 1'b0, 0, 1'b0);

        // Reset during the second RUN cycle aborts the operation.
        send(16'h1111, 16'h2222, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        seen = 1'b0;
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("abort_out_valid", out_valid, 0);
        check("abort_sum", sum_o, 0);
        check("abort_carry_out", cout_o, 0);
        check("abort_in_ready", in_ready, 1);
        run_op(16'h0003, 16'h0004, 1'b0, 0, 1'b0);

        for (int i = 0; i < 25; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'b0);
        end

        check("scoreboard_empty", 64'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
